// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control bus between the multi-cycle sequencer and the RISC datapath
//   master (sequencer): takes opcode/zero/mem_ready and drives the strobes.
//   slave  (datapath) : the mirror image.
//   opcode     instr[15:13] from IR
//   zero       ALU zero flag
//   mem_ready  memory access complete this cycle
//   ir_write, pc_write, pc_src, iord, mem_read, mem_write,
//   alu_src, alu_op, reg_write, reg_dst, mem_to_reg   datapath controls
interface multicycle_controller_if;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    modport master (
        input  opcode, zero, mem_ready,
        output ir_write, pc_write, pc_src, iord, mem_read, mem_write,
               alu_src, alu_op, reg_write, reg_dst, mem_to_reg
    );
    modport slave (
        output opcode, zero, mem_ready,
        input  ir_write, pc_write, pc_src, iord, mem_read, mem_write,
               alu_src, alu_op, reg_write, reg_dst, mem_to_reg
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer with run/halt, retire counter and memory-timeout trap
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        leave IDLE (ignored when busy)
//   halt         return to IDLE at the next instruction boundary
//   bus          control bus (master side)
//   busy         state is neither IDLE nor ERR
//   err          sticky memory-timeout flag
//   state        IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 ERR=7
//   instr_count  retired instructions, wraps
module multicycle_controller #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         halt,
    multicycle_controller_if.master      bus,
    output logic                         busy,
    output logic                         err,
    output logic [2:0]                   state,
    output logic [CNT_W-1:0]             instr_count
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [2:0] OP_R    = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_JMP  = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        ERR    = 3'd7
    } state_t;

    state_t          cur, nxt;
    logic [2:0]      op;
    logic [WW-1:0]   wait_cnt;
    logic            retire;
    logic            expire;

    // The access that is still not ready on the MEM_TIMEOUT-th cycle traps.
    assign expire = wait_cnt == WW'(MEM_TIMEOUT - 1);
    assign busy   = cur != IDLE && cur != ERR;
    assign state  = cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur         <= IDLE;
            op          <= '0;
            wait_cnt    <= '0;
            instr_count <= '0;
            err         <= 1'b0;
        end else begin
            cur <= nxt;
            if (cur == DECODE)
                op <= bus.opcode;
            // Only FETCH and MEM can repeat themselves, and only while waiting on memory.
            wait_cnt <= (nxt == cur && (cur == FETCH || cur == MEM)) ? wait_cnt + WW'(1) : '0;
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
            if (nxt == ERR)
                err <= 1'b1;
        end
    end

    always_comb begin
        nxt            = cur;
        retire         = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 2'b00;
        bus.iord       = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.alu_src    = 1'b0;
        bus.alu_op     = 2'b00;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        case (cur)
            IDLE: nxt = start ? FETCH : IDLE;
            FETCH: begin
                bus.mem_read = 1'b1;
                bus.ir_write = bus.mem_ready;
                bus.pc_write = bus.mem_ready;
                nxt          = bus.mem_ready ? DECODE : expire ? ERR : FETCH;
            end
            DECODE: begin
                retire = bus.opcode[2:1] == 2'b11;
                nxt    = EXEC;
            end
            EXEC: begin
                case (op)
                    OP_R: begin
                        bus.alu_op = 2'b10;
                        nxt        = WB;
                    end
                    OP_ADDI, OP_LW, OP_SW: begin
                        bus.alu_src = 1'b1;
                        nxt         = op == OP_ADDI ? WB : MEM;
                    end
                    OP_BEQ: begin
                        bus.alu_op   = 2'b01;
                        bus.pc_write = bus.zero;
                        bus.pc_src   = 2'b01;
                        retire       = 1'b1;
                    end
                    OP_JMP: begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = 2'b10;
                        retire       = 1'b1;
                    end
                    default: retire = 1'b1;
                endcase
            end
            MEM: begin
                bus.iord      = 1'b1;
                bus.alu_src   = 1'b1;
                bus.mem_read  = op == OP_LW;
                bus.mem_write = op == OP_SW;
                retire        = bus.mem_ready && op != OP_LW;
                nxt           = bus.mem_ready ? WB : expire ? ERR : MEM;
            end
            WB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = op == OP_R;
                bus.mem_to_reg = op == OP_LW;
                retire         = 1'b1;
            end
            ERR: nxt = ERR;
            default: nxt = IDLE;
        endcase
        if (retire)
            nxt = halt ? IDLE : FETCH;
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench for the multi-cycle sequencer
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       halt;
    logic       busy;
    logic       err;
    logic [2:0] state;
    logic [3:0] instr_count;
    int         total = 0;
    int         bad = 0;

    multicycle_controller_if bus();

    multicycle_controller #(.CNT_W(4), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .bus(bus),
        .busy(busy), .err(err), .state(state), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // strobe vector: ir_write pc_write pc_src iord mem_read mem_write alu_src alu_op reg_write reg_dst mem_to_reg
    localparam logic [12:0] NONE      = 13'b0_0_00_0_0_0_0_00_0_0_0;
    localparam logic [12:0] F_WAIT    = 13'b0_0_00_0_1_0_0_00_0_0_0;
    localparam logic [12:0] F_DONE    = 13'b1_1_00_0_1_0_0_00_0_0_0;
    localparam logic [12:0] EX_R      = 13'b0_0_00_0_0_0_0_10_0_0_0;
    localparam logic [12:0] EX_I      = 13'b0_0_00_0_0_0_1_00_0_0_0;
    localparam logic [12:0] EX_BEQ_Z  = 13'b0_1_01_0_0_0_0_01_0_0_0;
    localparam logic [12:0] EX_BEQ_NZ = 13'b0_0_01_0_0_0_0_01_0_0_0;
    localparam logic [12:0] EX_JMP    = 13'b0_1_10_0_0_0_0_00_0_0_0;
    localparam logic [12:0] MEM_LW    = 13'b0_0_00_1_1_0_1_00_0_0_0;
    localparam logic [12:0] MEM_SW    = 13'b0_0_00_1_0_1_1_00_0_0_0;
    localparam logic [12:0] WB_R      = 13'b0_0_00_0_0_0_0_00_1_1_0;
    localparam logic [12:0] WB_I      = 13'b0_0_00_0_0_0_0_00_1_0_0;
    localparam logic [12:0] WB_LW     = 13'b0_0_00_0_0_0_0_00_1_0_1;

    typedef struct {
        string       nm;
        logic [21:0] v;
    } exp_t;

    exp_t q[$];

    // {state, strobes, busy, err, instr_count}
    function automatic logic [21:0] actual();
        return {state, bus.ir_write, bus.pc_write, bus.pc_src, bus.iord, bus.mem_read,
                bus.mem_write, bus.alu_src, bus.alu_op, bus.reg_write, bus.reg_dst,
                bus.mem_to_reg, busy, err, instr_count};
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [21:0] a;
            e = q.pop_front();
            a = actual();
            total++;
            if (a !== e.v) begin
                bad++;
                $display("FAIL %s: got st=%0d sb=%b busy=%b err=%b cnt=%0d want st=%0d sb=%b busy=%b err=%b cnt=%0d",
                         e.nm, a[21:19], a[18:6], a[5], a[4], a[3:0],
                         e.v[21:19], e.v[18:6], e.v[5], e.v[4], e.v[3:0]);
            end
        end
    end

    // Queue what the DUT must show during the current cycle, then move to the next one.
    task automatic cyc(input string nm, input logic [2:0] st, input logic [12:0] sb,
                       input logic [3:0] cnt, input logic er = 1'b0);
        exp_t e;
        e.nm = nm;
        e.v  = {st, sb, st != 3'd0 && st != 3'd7, er, cnt};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fd(input string nm, input logic [3:0] cnt);
        cyc({nm, " fetch"}, 3'd1, F_DONE, cnt);
        cyc({nm, " decode"}, 3'd2, NONE, cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        halt = 1'b0;
        bus.opcode = 3'b000;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset", 3'd0, NONE, 4'd0);
        rst_n = 1'b1;
        start = 1'b1;
        cyc("idle start", 3'd0, NONE, 4'd0);
        start = 1'b0;
        // R-type
        fd("r", 4'd0);
        cyc("r exec", 3'd3, EX_R, 4'd0);
        cyc("r wb", 3'd5, WB_R, 4'd0);
        // ADDI
        bus.opcode = 3'b001;
        fd("addi", 4'd1);
        cyc("addi exec", 3'd3, EX_I, 4'd1);
        cyc("addi wb", 3'd5, WB_I, 4'd1);
        // LW with three wait cycles
        bus.opcode = 3'b010;
        fd("lw", 4'd2);
        cyc("lw exec", 3'd3, EX_I, 4'd2);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc("lw mem wait", 3'd4, MEM_LW, 4'd2);
        bus.mem_ready = 1'b1;
        cyc("lw mem done", 3'd4, MEM_LW, 4'd2);
        cyc("lw wb", 3'd5, WB_LW, 4'd2);
        // BEQ taken / not taken, JMP
        bus.opcode = 3'b100;
        fd("beq z", 4'd3);
        bus.zero = 1'b1;
        cyc("beq z exec", 3'd3, EX_BEQ_Z, 4'd3);
        bus.zero = 1'b0;
        fd("beq nz", 4'd4);
        cyc("beq nz exec", 3'd3, EX_BEQ_NZ, 4'd4);
        bus.opcode = 3'b101;
        fd("jmp", 4'd5);
        cyc("jmp exec", 3'd3, EX_JMP, 4'd5);
        // SW with halt raised during EXEC
        bus.opcode = 3'b011;
        fd("sw", 4'd6);
        halt = 1'b1;
        cyc("sw exec", 3'd3, EX_I, 4'd6);
        cyc("sw mem", 3'd4, MEM_SW, 4'd6);
        start = 1'b1;
        cyc("halted idle", 3'd0, NONE, 4'd7);
        start = 1'b0;
        halt = 1'b0;
        // NOPs across the counter wrap
        for (int i = 0; i < 9; i++) begin
            bus.opcode = i[0] ? 3'b111 : 3'b110;
            fd("nop", 4'(7 + i));
        end
        // Fetch timeout
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 15; i++)
            cyc("fetch wait", 3'd1, F_WAIT, 4'd0);
        start = 1'b1;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            cyc("err hold", 3'd7, NONE, 4'd0, 1'b1);
        rst_n = 1'b0;
        cyc("err reset", 3'd0, NONE, 4'd0);
        rst_n = 1'b1;
        bus.mem_ready = 1'b0;
        bus.opcode = 3'b110;
        cyc("restart idle", 3'd0, NONE, 4'd0);
        start = 1'b0;
        // Ready arriving on the last allowed cycle completes the fetch
        for (int i = 0; i < 14; i++)
            cyc("late fetch wait", 3'd1, F_WAIT, 4'd0);
        bus.mem_ready = 1'b1;
        fd("late fetch", 4'd0);
        // Reset in the middle of a fetch drops strobes without a clock edge
        bus.mem_ready = 1'b0;
        cyc("fetch before rst", 3'd1, F_WAIT, 4'd1);
        rst_n = 1'b0;
        cyc("async rst", 3'd0, NONE, 4'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
